// File: rtl/cf_shift_collect_pkg.sv
// Shared constants and types for the cipher-state byte collector.
// The byte-rotate/unload register uses the same low-byte-first ordering.
package cf_shift_collect_pkg;

    localparam int WORD_BYTES = 16;
    localparam int LANE_BYTES = 4;
    localparam int WORD_W     = 8 * WORD_BYTES;
    localparam int LANE_W     = 8 * LANE_BYTES;

    typedef logic [4:0] byte_cnt_t;
    typedef logic [2:0] lane_len_t;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_e;

    localparam lane_len_t LEN_1B = 3'd1;
    localparam lane_len_t LEN_2B = 3'd2;
    localparam lane_len_t LEN_3B = 3'd3;
    localparam lane_len_t LEN_4B = 3'd4;

    function automatic logic len_legal(input lane_len_t len);
        return (len >= LEN_1B) && (len <= LEN_4B);
    endfunction

endpackage

// File: rtl/cf_shift_collect_if.sv
// Beat-in / word-out handshake bundle for cf_shift_collect.
// Upstream and downstream share one bundle; the collector is the slave.
interface cf_shift_collect_if;
    import cf_shift_collect_pkg::*;

    logic              in_valid;
    logic              in_ready;
    lane_len_t         in_len;
    logic [LANE_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_len,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_len,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/cf_byte_insert.sv
// Shifts m new bytes into the top of the accumulator; older bytes move down.
// The oldest byte of the beat lands lowest among the newly inserted bytes.
module cf_byte_insert
    import cf_shift_collect_pkg::*;
(
    input  logic [WORD_W-1:0] acc_base,
    input  logic [LANE_W-1:0] in_data,
    input  lane_len_t         m,
    output logic [WORD_W-1:0] acc_next
);

    always_comb begin
        acc_next = acc_base;
        case (m)
            LEN_1B:  acc_next = {in_data[7:0],  acc_base[WORD_W-1:8]};
            LEN_2B:  acc_next = {in_data[15:0], acc_base[WORD_W-1:16]};
            LEN_3B:  acc_next = {in_data[23:0], acc_base[WORD_W-1:24]};
            LEN_4B:  acc_next = {in_data[31:0], acc_base[WORD_W-1:32]};
            default: acc_next = acc_base;
        endcase
    end

endmodule

// File: rtl/cf_shift_collect.sv
// Assembles a 128-bit cipher-state word from 1..4 byte beats, first byte in [7:0],
// and hands the finished word downstream over a valid/ready handshake.
module cf_shift_collect
    import cf_shift_collect_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    cf_shift_collect_if.slave   bus,
    output byte_cnt_t           cnt,
    output logic                err
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] acc_q,   acc_d;
    byte_cnt_t         cnt_q,   cnt_d;
    logic              err_q,   err_d;

    logic              out_valid;
    logic              hand_off;
    logic              accept;
    logic              len_ok;
    logic              len_over;
    logic [WORD_W-1:0] acc_base;
    byte_cnt_t         base_cnt;
    byte_cnt_t         room;
    lane_len_t         m;
    logic [WORD_W-1:0] acc_ins;

    assign out_valid     = (state_q == ST_FULL);
    assign bus.out_valid = out_valid;
    assign bus.out_data  = acc_q;
    assign bus.in_ready  = !out_valid || bus.out_ready;
    assign cnt           = cnt_q;
    assign err           = err_q;

    assign hand_off = out_valid && bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;
    assign len_ok   = len_legal(bus.in_len);

    // A word leaving this cycle frees the whole accumulator for the incoming beat.
    assign acc_base = hand_off ? '0 : acc_q;
    assign base_cnt = hand_off ? '0 : cnt_q;
    assign room     = byte_cnt_t'(WORD_BYTES) - base_cnt;
    assign len_over = ({2'b00, bus.in_len} > room);
    assign m        = len_over ? room[2:0] : bus.in_len;

    cf_byte_insert u_byte_insert (
        .acc_base (acc_base),
        .in_data  (bus.in_data),
        .m        (m),
        .acc_next (acc_ins)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (clr) begin
            // Pending word and any same-cycle beat are dropped; err is sticky.
            state_d = ST_FILL;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            if (hand_off) begin
                state_d = ST_FILL;
                acc_d   = acc_base;
                cnt_d   = base_cnt;
            end
            if (accept) begin
                if (len_ok) begin
                    acc_d = acc_ins;
                    cnt_d = base_cnt + {2'b00, m};
                    if (cnt_d == byte_cnt_t'(WORD_BYTES)) begin
                        state_d = ST_FULL;
                    end
                    if (len_over) begin
                        err_d = 1'b1;
                    end
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_cf_shift_collect.sv
// Directed bench for cf_shift_collect: packing order, overflow, back-pressure,
// clear and illegal-length handling against hand-computed words.
module tb_cf_shift_collect;
    import cf_shift_collect_pkg::*;

    logic      clk;
    logic      rst;
    logic      clr;
    byte_cnt_t cnt;
    logic      err;
    int        checks;
    int        errors;
    logic [127:0] held;

    cf_shift_collect_if bus ();

    cf_shift_collect dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus.slave),
        .cnt (cnt),
        .err (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] len, input logic [31:0] data);
        bus.in_valid = 1'b1;
        bus.in_len   = len;
        bus.in_data  = data;
        tick();
        bus.in_valid = 1'b0;
        bus.in_len   = 3'd0;
        bus.in_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_len    = 3'd0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        do_reset();

        chk("rst_cnt", 128'(cnt), 128'd0);
        chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
        chk("rst_out_data", bus.out_data, 128'd0);

        // Four full-lane beats, bytes 0x00..0x0F
        beat(3'd4, 32'h03020100);
        beat(3'd4, 32'h07060504);
        beat(3'd4, 32'h0B0A0908);
        chk("seq4_cnt12", 128'(cnt), 128'd12);
        chk("seq4_not_valid", 128'(bus.out_valid), 128'd0);
        beat(3'd4, 32'h0F0E0D0C);
        chk("seq4_valid", 128'(bus.out_valid), 128'd1);
        chk("seq4_data", bus.out_data, 128'h0F0E0D0C0B0A09080706050403020100);
        chk("seq4_cnt16", 128'(cnt), 128'd16);
        chk("seq4_err", 128'(err), 128'd0);
        chk("seq4_in_ready_low", 128'(bus.in_ready), 128'd0);

        // Plain hand-off with no beat
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("handoff_valid", 128'(bus.out_valid), 128'd0);
        chk("handoff_cnt", 128'(cnt), 128'd0);

        // Mixed lengths 1,2,3,4,4,2 carrying 0xA0..0xAF
        beat(3'd1, 32'h000000A0);
        beat(3'd2, 32'h0000A2A1);
        beat(3'd3, 32'h00A5A4A3);
        beat(3'd4, 32'hA9A8A7A6);
        beat(3'd4, 32'hADACABAA);
        chk("mix_cnt14", 128'(cnt), 128'd14);
        chk("mix_not_valid", 128'(bus.out_valid), 128'd0);
        beat(3'd2, 32'h0000AFAE);
        chk("mix_valid", 128'(bus.out_valid), 128'd1);
        chk("mix_data", bus.out_data, 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0);

        // Back-pressure: word must hold while out_ready is low
        held = bus.out_data;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 128'(bus.in_ready), 128'd0);
            chk("bp_hold", bus.out_data, held);
            tick();
        end

        // Hand-off and new beat in the same cycle
        bus.out_ready = 1'b1;
        beat(3'd2, 32'h0000BEEF);
        bus.out_ready = 1'b0;
        chk("pass_valid", 128'(bus.out_valid), 128'd0);
        chk("pass_cnt", 128'(cnt), 128'd2);
        chk("pass_data", bus.out_data, {16'hBEEF, 112'd0});

        // Overflow at cnt=14: only 0x11,0x22 taken
        beat(3'd4, 32'h0);
        beat(3'd4, 32'h0);
        beat(3'd4, 32'h0);
        chk("ovf_cnt14", 128'(cnt), 128'd14);
        chk("ovf_err_before", 128'(err), 128'd0);
        beat(3'd4, 32'h44332211);
        chk("ovf_valid", 128'(bus.out_valid), 128'd1);
        chk("ovf_cnt16", 128'(cnt), 128'd16);
        chk("ovf_top", 128'(bus.out_data[127:112]), 128'h2211);
        chk("ovf_err", 128'(err), 128'd1);

        // clr drops the pending word but leaves err alone
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_full_valid", 128'(bus.out_valid), 128'd0);
        chk("clr_full_err", 128'(err), 128'd1);
        do_reset();
        chk("rst_clears_err", 128'(err), 128'd0);

        // cnt=9 then clr with a beat present
        beat(3'd4, 32'h11111111);
        beat(3'd4, 32'h22222222);
        beat(3'd1, 32'h00000033);
        chk("clr_cnt9", 128'(cnt), 128'd9);
        clr = 1'b1;
        chk("clr_in_ready", 128'(bus.in_ready), 128'd1);
        beat(3'd4, 32'h55555555);
        clr = 1'b0;
        chk("clr_cnt", 128'(cnt), 128'd0);
        chk("clr_acc", bus.out_data, 128'd0);
        chk("clr_err", 128'(err), 128'd0);

        // Illegal lengths consume the beat without data change
        beat(3'd2, 32'h00001234);
        beat(3'd0, 32'hFFFFFFFF);
        chk("len0_cnt", 128'(cnt), 128'd2);
        chk("len0_err", 128'(err), 128'd1);
        chk("len0_data", bus.out_data, {16'h1234, 112'd0});
        beat(3'd5, 32'hFFFFFFFF);
        chk("len5_cnt", 128'(cnt), 128'd2);
        chk("len5_data", bus.out_data, {16'h1234, 112'd0});

        // Reset mid-word
        do_reset();
        chk("rst2_err", 128'(err), 128'd0);
        chk("rst2_cnt", 128'(cnt), 128'd0);
        chk("rst2_data", bus.out_data, 128'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
